mb_residue_reader: RTL and testbench
====================================

# mb_residue_reader

Reads back one macroblock's prediction mode and residue block from the intra-prediction frame stores and streams it out in raster order. It is the read side of the intra-prediction result path: the saver writes chosen modes and residues, and this block fetches them for the downstream consumer (entropy coder or reconstruction). Memory read ports have fixed 1-cycle latency. The output is a valid/ready byte stream with full backpressure.

## Interface

Parameters:
- LENGTH, 1280: frame width in pixels.
- WIDTH, 720: frame height in pixels.
- MB_SIZE_L, 8: macroblock width (4, 8 or 16).
- MB_SIZE_W, 8: macroblock height (4, 8 or 16).
- MBN_W, 14: macroblock-number width.
- ADDR_W, 20: residue-store address width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; accepted only when busy=0.
- mbnumber  in  MBN_W  macroblock index, sampled with start.
- busy  out  1  high while a request is in progress.
- err  out  1  one-cycle pulse when a request is out of range.
- mode_rd_addr  out  MBN_W  mode-store read address.
- mode_rd_data  in  3  mode-store data, valid 1 cycle after the address.
- res_rd_en  out  1  residue-store read strobe.
- res_rd_addr  out  ADDR_W  residue-store read address.
- res_rd_data  in  8  residue data, valid 1 cycle after res_rd_en.
- out_valid  out  1  output byte valid.
- out_ready  in  1  consumer ready.
- out_data  out  8  residue byte.
- out_mode  out  3  mode of the current block; held for the whole block.
- out_last  out  1  high with the final byte of the block.

## Operation

- Constants: K1 = LENGTH/MB_SIZE_L, K2 = WIDTH/MB_SIZE_W, NMB = K1*K2, NPIX = MB_SIZE_L*MB_SIZE_W.
- FSM states: IDLE, MODE_RD, MODE_WAIT, STREAM, DRAIN.
- **IDLE**
  - start=1 with mbnumber < NMB: latch mbnumber, go to MODE_RD.
  - start=1 with mbnumber ≥ NMB: pulse err and stay in IDLE; no memory access.
- **MODE_RD:** drive mode_rd_addr = mbnumber. Compute mbx = mbnumber % K1 and mby = mbnumber / K1 (constant divisor, registered), then base = (mby*MB_SIZE_W)*LENGTH + mbx*MB_SIZE_L.
- **MODE_WAIT:** capture mode_rd_data into out_mode, go to STREAM.
- **STREAM:**
  - Counters i (row, 0..MB_SIZE_W-1) and j (column, 0..MB_SIZE_L-1), j fastest.
  - res_rd_addr = base + i*LENGTH + j.
  - Returned data goes into a 2-entry FIFO.
  - Issue a read only when fifo_count + inflight < 2.
  - After the read at (MB_SIZE_W-1, MB_SIZE_L-1), go to DRAIN.
- **DRAIN:** when the FIFO is empty and nothing is in flight, go to IDLE and drop busy.
- Output: out_valid = FIFO not empty; out_data = FIFO head. A byte transfers on out_valid && out_ready.
- out_last: set on the head entry whose index is NPIX-1. It is tagged into the FIFO with the data.
- Bytes are never dropped, duplicated or reordered.
- start while busy=1 is ignored.

## Timing

- Reset values:
  - busy=0, err=0, out_valid=0, out_last=0, res_rd_en=0.
  - mode_rd_addr=0, res_rd_addr=0, out_data=0, out_mode=0.
  - FSM in IDLE; FIFO and counters cleared.
- start in cycle T:
  - busy=1 from T+1.
  - mode_rd_addr valid in T+1; out_mode valid from T+3.
  - First res_rd_en in T+3; first out_valid in T+4.
- With out_ready held high: one byte per cycle, and the last byte arrives at T+3+NPIX.
- busy falls in the cycle after the last byte's handshake.
- Backpressure: with out_ready=0, at most 2 reads are outstanding (FIFO plus in-flight); address issue stalls until space frees.
- Asynchronous reset mid-stream: return to IDLE immediately, clear the FIFO, and drop out_valid. In-flight read data is discarded.

## Structure

- Shared intrapred package holds:
  - the mode enum (3-bit);
  - the K1/K2/NMB/NPIX derivation functions;
  - the rule that the residue store address width is ceil(log2(LENGTH*WIDTH)).
  - The saver uses the same package.
- One sub-module: `skid_fifo2`, a 2-entry FIFO with a 9-bit payload (data + last) and count output.

## Test plan

- mbnumber=0, out_ready=1 → res_rd_addr sequence 0..7, 1280..1287, …, 8960..8967; 64 bytes; out_last on byte 64; out_mode equals the stored mode.
- mbnumber=161 → mbx=1, mby=1, base 10248; first addresses 10248..10255, last address 19215.
- mbnumber=14399 → base 912632; final address 921599.
- mbnumber=14400 → err high for one cycle; busy stays 0; no res_rd_en or mode read.
- out_ready toggled at random, including 5 consecutive low cycles mid-block → all 64 bytes match the store in order; never more than 2 outstanding.
- reset asserted at byte 20 → outputs at reset values in the same cycle; a new start for mbnumber=0 then completes normally; start pulsed while busy → ignored.

Source files
------------

// File: rtl/mb_residue_reader_pkg.sv
// Shared intra-prediction definitions: mode encoding, reader FSM states and
// frame/macroblock geometry helpers used by both the saver and the reader.
package mb_residue_reader_pkg;

  typedef enum logic [2:0] {
    MODE_VERT    = 3'd0,
    MODE_HORZ    = 3'd1,
    MODE_DC      = 3'd2,
    MODE_DIAG_DL = 3'd3,
    MODE_DIAG_DR = 3'd4,
    MODE_VERT_R  = 3'd5,
    MODE_HORZ_D  = 3'd6,
    MODE_VERT_L  = 3'd7
  } intra_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MODE_RD   = 3'd1,
    ST_MODE_WAIT = 3'd2,
    ST_STREAM    = 3'd3,
    ST_DRAIN     = 3'd4
  } rd_state_e;

  function automatic int unsigned calc_k1(input int unsigned length, input int unsigned mb_l);
    return length / mb_l;
  endfunction

  function automatic int unsigned calc_k2(input int unsigned width, input int unsigned mb_w);
    return width / mb_w;
  endfunction

  function automatic int unsigned calc_nmb(input int unsigned length, input int unsigned width,
                                           input int unsigned mb_l, input int unsigned mb_w);
    return calc_k1(length, mb_l) * calc_k2(width, mb_w);
  endfunction

  function automatic int unsigned calc_npix(input int unsigned mb_l, input int unsigned mb_w);
    return mb_l * mb_w;
  endfunction

  // Residue store holds one byte per frame pixel.
  function automatic int unsigned res_addr_w(input int unsigned length, input int unsigned width);
    return $clog2(length * width);
  endfunction

endpackage

// File: rtl/mb_residue_reader_skid_fifo2.sv
// Two-entry FIFO with empty bypass: pushed data is visible at the head in the same cycle.
// Caller guarantees no push when full (count + in-flight is bounded upstream).
module skid_fifo2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_vld,
  input  logic [8:0] push_dat,
  output logic       pop_vld,
  input  logic       pop_rdy,
  output logic [8:0] pop_dat,
  output logic [1:0] count
);

  logic [8:0] mem_q [2];
  logic [8:0] mem_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       pop, bypass, store, deq;

  always_comb begin
    pop_vld  = (cnt_q != 2'd0) || push_vld;
    pop_dat  = (cnt_q != 2'd0) ? mem_q[rd_ptr_q] : (push_vld ? push_dat : 9'd0);
    pop      = pop_vld && pop_rdy;
    bypass   = (cnt_q == 2'd0) && pop;
    store    = push_vld && !bypass;
    deq      = pop && (cnt_q != 2'd0);
    mem_d    = mem_q;
    if (store) mem_d[wr_ptr_q] = push_dat;
    wr_ptr_d = wr_ptr_q ^ store;
    rd_ptr_d = rd_ptr_q ^ deq;
    cnt_d    = cnt_q + {1'b0, store} - {1'b0, deq};
  end

  assign count = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mb_residue_reader.sv
// Fetches one macroblock's mode and residue bytes and streams them in raster order.
// First byte 4 cycles after start; reads throttle so FIFO plus in-flight never exceeds 2.
module mb_residue_reader
  import mb_residue_reader_pkg::*;
#(
  parameter int LENGTH    = 1280,
  parameter int WIDTH     = 720,
  parameter int MB_SIZE_L = 8,
  parameter int MB_SIZE_W = 8,
  parameter int MBN_W     = 14,
  parameter int ADDR_W    = res_addr_w(LENGTH, WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MBN_W-1:0]  mbnumber,
  output logic              busy,
  output logic              err,
  output logic [MBN_W-1:0]  mode_rd_addr,
  input  logic [2:0]        mode_rd_data,
  output logic              res_rd_en,
  output logic [ADDR_W-1:0] res_rd_addr,
  input  logic [7:0]        res_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [2:0]        out_mode,
  output logic              out_last
);

  localparam int unsigned K1  = calc_k1(LENGTH, MB_SIZE_L);
  localparam int unsigned NMB = calc_nmb(LENGTH, WIDTH, MB_SIZE_L, MB_SIZE_W);
  localparam int IW = (MB_SIZE_W > 1) ? $clog2(MB_SIZE_W) : 1;
  localparam int JW = (MB_SIZE_L > 1) ? $clog2(MB_SIZE_L) : 1;

  rd_state_e         state_q, state_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [MBN_W-1:0]  mbn_q, mbn_d;
  logic [MBN_W-1:0]  mbx_q, mbx_d;
  logic [MBN_W-1:0]  mby_q, mby_d;
  intra_mode_e       out_mode_q, out_mode_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [IW-1:0]     i_q, i_d;
  logic [JW-1:0]     j_q, j_d;
  logic              res_rd_en_q, res_rd_en_d;
  logic [ADDR_W-1:0] res_rd_addr_q, res_rd_addr_d;
  logic              rd_last_q, rd_last_d;
  logic              arr_vld_q, arr_vld_d;
  logic              arr_last_q, arr_last_d;

  logic [8:0]        fifo_head;
  logic [1:0]        fifo_cnt;
  logic [2:0]        fifo_cnt_nxt;
  logic              issue_ok;
  logic [ADDR_W-1:0] base;

  skid_fifo2 u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push_vld (arr_vld_q),
    .push_dat ({arr_last_q, res_rd_data}),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (fifo_head),
    .count    (fifo_cnt)
  );

  always_comb begin
    // Occupancy after this edge, so a pop this cycle frees room for back-to-back reads.
    fifo_cnt_nxt = {1'b0, fifo_cnt} + {2'b0, arr_vld_q} - {2'b0, out_valid && out_ready};
    issue_ok     = (fifo_cnt_nxt + {2'b0, res_rd_en_q}) < 3'd2;
    base         = ADDR_W'(32'(mby_q) * 32'(MB_SIZE_W * LENGTH) + 32'(mbx_q) * 32'(MB_SIZE_L));

    state_d       = state_q;
    busy_d        = busy_q;
    err_d         = 1'b0;
    mbn_d         = mbn_q;
    mbx_d         = mbx_q;
    mby_d         = mby_q;
    out_mode_d    = out_mode_q;
    row_base_d    = row_base_q;
    i_d           = i_q;
    j_d           = j_q;
    res_rd_en_d   = 1'b0;
    res_rd_addr_d = res_rd_addr_q;
    rd_last_d     = 1'b0;
    arr_vld_d     = res_rd_en_q;
    arr_last_d    = rd_last_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (32'(mbnumber) < NMB) begin
            mbn_d   = mbnumber;
            busy_d  = 1'b1;
            state_d = ST_MODE_RD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_MODE_RD: begin
        mbx_d   = MBN_W'(32'(mbn_q) % K1);
        mby_d   = MBN_W'(32'(mbn_q) / K1);
        state_d = ST_MODE_WAIT;
      end
      ST_MODE_WAIT: begin
        // FIFO is empty here, so the first read goes out unconditionally.
        out_mode_d    = intra_mode_e'(mode_rd_data);
        row_base_d    = base;
        i_d           = '0;
        j_d           = JW'(1);
        res_rd_en_d   = 1'b1;
        res_rd_addr_d = base;
        state_d       = ST_STREAM;
      end
      ST_STREAM: begin
        if (issue_ok) begin
          res_rd_en_d   = 1'b1;
          res_rd_addr_d = row_base_q + ADDR_W'(j_q);
          if (j_q == JW'(MB_SIZE_L - 1)) begin
            j_d = '0;
            if (i_q == IW'(MB_SIZE_W - 1)) begin
              rd_last_d = 1'b1;
              state_d   = ST_DRAIN;
            end else begin
              i_d        = i_q + IW'(1);
              row_base_d = row_base_q + ADDR_W'(LENGTH);
            end
          end else begin
            j_d = j_q + JW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_cnt_nxt == 3'd0 && !res_rd_en_q) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      mbn_q         <= '0;
      mbx_q         <= '0;
      mby_q         <= '0;
      out_mode_q    <= MODE_VERT;
      row_base_q    <= '0;
      i_q           <= '0;
      j_q           <= '0;
      res_rd_en_q   <= 1'b0;
      res_rd_addr_q <= '0;
      rd_last_q     <= 1'b0;
      arr_vld_q     <= 1'b0;
      arr_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      mbn_q         <= mbn_d;
      mbx_q         <= mbx_d;
      mby_q         <= mby_d;
      out_mode_q    <= out_mode_d;
      row_base_q    <= row_base_d;
      i_q           <= i_d;
      j_q           <= j_d;
      res_rd_en_q   <= res_rd_en_d;
      res_rd_addr_q <= res_rd_addr_d;
      rd_last_q     <= rd_last_d;
      arr_vld_q     <= arr_vld_d;
      arr_last_q    <= arr_last_d;
    end
  end

  assign busy         = busy_q;
  assign err          = err_q;
  assign mode_rd_addr = mbn_q;
  assign res_rd_en    = res_rd_en_q;
  assign res_rd_addr  = res_rd_addr_q;
  assign out_mode     = out_mode_q;
  assign out_data     = fifo_head[7:0];
  assign out_last     = fifo_head[8];

endmodule

// File: tb/tb_mb_residue_reader.sv
// Bench for mb_residue_reader: memory models, a raster-order reference model and
// a per-cycle compare process, driven by directed and randomized requests.
`timescale 1ns/1ps
module tb_mb_residue_reader;

  localparam int L    = 1280;
  localparam int MBL  = 8;
  localparam int MBW  = 8;
  localparam int NPIX = MBL * MBW;
  localparam int K1   = 1280 / 8;
  localparam int NMB  = K1 * (720 / 8);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [13:0] mbnumber = '0;
  logic        busy, err;
  logic [13:0] mode_rd_addr;
  logic [2:0]  mode_rd_data = '0;
  logic        res_rd_en;
  logic [19:0] res_rd_addr;
  logic [7:0]  res_rd_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic [2:0]  out_mode;
  logic        out_last;

  mb_residue_reader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mbnumber     (mbnumber),
    .busy         (busy),
    .err          (err),
    .mode_rd_addr (mode_rd_addr),
    .mode_rd_data (mode_rd_data),
    .res_rd_en    (res_rd_en),
    .res_rd_addr  (res_rd_addr),
    .res_rd_data  (res_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_mode     (out_mode),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  bit active = 1'b0;
  int exp_mb = 0, rd_idx = 0, out_idx = 0, issued = 0, delivered = 0, max_out = 0;
  int first_rd_cyc = -1, first_vld_cyc = -1, last_out_cyc = -1;
  int first_addr = -1, last_addr = -1;

  function automatic logic [7:0] res_val(input int addr);
    return 8'((addr * 131) ^ (addr >> 7) ^ 8'h3c);
  endfunction

  function automatic logic [2:0] mode_val(input int mb);
    return 3'((mb * 7 + 5) ^ (mb >> 3));
  endfunction

  // Raster position k of macroblock mb mapped to a frame pixel address.
  function automatic int exp_addr(input int mb, input int k);
    int px, py;
    px = (mb % K1) * MBL + (k % MBL);
    py = (mb / K1) * MBW + (k / MBL);
    return py * L + px;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: mode store and residue store, both with one-cycle read latency.
  always @(posedge clk) begin
    mode_rd_data <= mode_val(32'(mode_rd_addr));
    if (res_rd_en) res_rd_data <= res_val(32'(res_rd_addr));
    else           res_rd_data <= 8'($urandom);
  end

  always @(negedge clk) begin
    if (reset) begin
      if (!active) begin
        if (res_rd_en || out_valid) check("idle_activity", {30'b0, res_rd_en, out_valid}, 32'd0);
      end else begin
        if (res_rd_en) begin
          if (rd_idx < NPIX) check("rd_addr", 32'(res_rd_addr), exp_addr(exp_mb, rd_idx));
          else               check("extra_read", rd_idx, NPIX - 1);
          if (rd_idx == 0) begin
            first_rd_cyc = cyc;
            first_addr   = 32'(res_rd_addr);
          end
          last_addr = 32'(res_rd_addr);
          rd_idx++;
          issued++;
        end
        if (issued - delivered > max_out) max_out = issued - delivered;
        if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (out_valid && out_ready) begin
          if (out_idx < NPIX) begin
            check("out_data", 32'(out_data), 32'(res_val(exp_addr(exp_mb, out_idx))));
            check("out_last", 32'(out_last), 32'(out_idx == NPIX - 1));
            check("out_mode", 32'(out_mode), 32'(mode_val(exp_mb)));
          end else begin
            check("extra_byte", out_idx, NPIX - 1);
          end
          if (out_idx == NPIX - 1) last_out_cyc = cyc;
          out_idx++;
          delivered++;
        end
      end
    end
  end

  task automatic clear_model(input int mb);
    exp_mb = mb; rd_idx = 0; out_idx = 0; issued = 0; delivered = 0; max_out = 0;
    first_rd_cyc = -1; first_vld_cyc = -1; last_out_cyc = -1;
    first_addr = -1; last_addr = -1;
  endtask

  task automatic check_reset_vals();
    check("rst_busy",      32'(busy), 0);
    check("rst_err",       32'(err), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_last",  32'(out_last), 0);
    check("rst_res_rd_en", 32'(res_rd_en), 0);
    check("rst_mode_addr", 32'(mode_rd_addr), 0);
    check("rst_res_addr",  32'(res_rd_addr), 0);
    check("rst_out_data",  32'(out_data), 0);
    check("rst_out_mode",  32'(out_mode), 0);
  endtask

  // rmode: 0 = ready held high, 1 = random ready, 2 = random plus a 5-cycle stall mid-block.
  task automatic run_req(input int mb, input int rmode, input bit poke,
                         input int exp_first, input int exp_last);
    int t0, g, low_left;
    bit burst_done;
    clear_model(mb);
    low_left = 0;
    burst_done = 1'b0;
    @(posedge clk); #1;
    out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    active = 1'b1;
    start = 1'b1;
    mbnumber = 14'(mb);
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_rise", 32'(busy), 1);
    check("mode_rd_addr", 32'(mode_rd_addr), mb);
    g = 0;
    while (busy && g < 3000) begin
      @(posedge clk); #1;
      g++;
      if (poke && g == 8) begin
        start = 1'b1;
        mbnumber = 14'((mb + 1) % NMB);
      end else begin
        start = 1'b0;
      end
      if (rmode == 0) out_ready = 1'b1;
      else if (low_left > 0) begin
        out_ready = 1'b0;
        low_left--;
      end else if (rmode == 2 && !burst_done && out_idx >= 30) begin
        out_ready = 1'b0;
        low_left = 4;
        burst_done = 1'b1;
      end else begin
        out_ready = 1'($urandom_range(0, 3) != 0);
      end
    end
    start = 1'b0;
    check("done_in_time", 32'(g < 3000), 1);
    check("bytes_out", delivered, NPIX);
    check("reads_issued", issued, NPIX);
    check("outstanding_le2", 32'(max_out <= 2), 1);
    check("busy_fall", cyc, last_out_cyc + 1);
    if (exp_first >= 0) begin
      check("first_addr", first_addr, exp_first);
      check("last_addr", last_addr, exp_last);
    end
    if (rmode == 0) begin
      check("first_rd_cycle", first_rd_cyc - t0, 3);
      check("first_vld_cycle", first_vld_cyc - t0, 4);
      check("last_byte_cycle", last_out_cyc - t0, 3 + NPIX);
    end
    active = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic err_req(input int mb);
    @(posedge clk); #1;
    start = 1'b1;
    mbnumber = 14'(mb);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("err_pulse", 32'(err), 1);
    check("err_busy", 32'(busy), 0);
    @(negedge clk);
    check("err_clear", 32'(err), 0);
    check("err_busy2", 32'(busy), 0);
  endtask

  initial begin
    int g;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    reset = 1'b1;

    run_req(0, 0, 1'b0, 0, 8967);
    run_req(161, 0, 1'b0, 10248, 19215);
    run_req(14399, 0, 1'b0, 912632, 921599);
    err_req(14400);
    err_req(16383);
    run_req(0, 2, 1'b0, 0, 8967);
    for (int n = 0; n < 6; n++) run_req(int'($urandom_range(0, NMB - 1)), 1, 1'b0, -1, -1);
    run_req(int'($urandom_range(0, NMB - 1)), 2, 1'b0, -1, -1);

    // Reset while the block is mid-stream.
    @(posedge clk); #1;
    clear_model(0);
    active = 1'b1;
    out_ready = 1'b1;
    start = 1'b1;
    mbnumber = 14'd0;
    @(posedge clk); #1;
    start = 1'b0;
    g = 0;
    while (out_idx < 20 && g < 500) begin
      @(posedge clk);
      g++;
    end
    check("rst_reach_byte20", 32'(g < 500), 1);
    #3;
    active = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_vals();
    @(posedge clk); #1;
    reset = 1'b1;

    run_req(0, 0, 1'b1, 0, 8967);
    run_req(161, 1, 1'b1, 10248, 19215);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
